mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle multiply/divide unit for the MIPS execute stage, sitting beside the ALU and fed from the same register-file operand buses A and B. It executes MULT, MULTU, DIV and DIVU iteratively over 32 cycles and owns the architectural HI/LO registers, which MFHI/MFLO read and MTHI/MTLO write. The control unit starts an operation with a one-cycle Start pulse and stalls on Busy; Done marks the cycle HI/LO become valid.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is required to be supported.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- Start  input  1  start request; sampled only in IDLE.
- MDOp  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  input  32  rs operand (multiplicand / dividend).
- B  input  32  rt operand (multiplier / divisor).
- HIWrite  input  1  MTHI: load WriteData into HI.
- LOWrite  input  1  MTLO: load WriteData into LO.
- WriteData  input  32  data for MTHI/MTLO.
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse; HI/LO hold the new result.
- DivByZero  output  1  one-cycle pulse with Done when a DIV/DIVU had B == 0.
- HI  output  32  HI register (product [63:32] / remainder).
- LO  output  32  LO register (product [31:0] / quotient).

## Operation
- States: IDLE, CALC, FIX.
- IDLE -> CALC on Start. Latch MDOp, sign flags and operand magnitudes. Signed ops use |A| and |B|; unsigned ops use raw values. Clear the 64-bit accumulator/remainder. Load the iteration counter with 31.
- CALC, multiply: one radix-2 shift-add step per cycle on a 64-bit product.
- CALC, divide: one restoring-division step per cycle, with a 33-bit trial subtract.
- CALC -> FIX when the counter is 0 after a step. That is exactly 32 CALC cycles.
- FIX -> IDLE unconditionally. In this transition:
  - Apply sign correction and write HI/LO.
  - Pulse Done.
  - Pulse DivByZero if applicable.
- Sign rules:
  - MULT: negate the 64-bit product if sign(A) xor sign(B).
  - DIV: the quotient is negative if sign(A) xor sign(B); the remainder takes sign(A).
- DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000 and HI = 0. This falls out of magnitude arithmetic and needs no trap.
- Divide by zero (B == 0, DIV or DIVU): full latency still applies. Result is LO = 0xFFFFFFFF and HI = A (raw). DivByZero = 1 together with Done.
- Start while not IDLE: ignored. Operands are not re-latched.
- HIWrite/LOWrite:
  - Take effect only in IDLE; ignored while Busy.
  - In IDLE, a write together with Start performs the write, then accepts Start. The final result overwrites it.
- A and B may change after the Start cycle without affecting the result.
- Reset (reset == 0 at a rising edge): state = IDLE and the operation is aborted. HI = LO = 0, Busy = Done = DivByZero = 0.

## Timing
- Edge E0 samples Start in IDLE. Busy = 1 from after E0 through after E32 (33 cycles). Busy is registered and equals (state != IDLE).
- E1..E32 are the CALC steps. E33 is the FIX edge: HI/LO are updated, Done = 1 and Busy = 0 for the cycle after E33.
- Latency from Start to Done is 34 rising edges counting E0. A new Start is accepted in the same cycle that Done = 1, since state is IDLE.
- Done and DivByZero are registered and high for exactly one cycle.
- HI/LO are registered and change only at FIX, on an accepted MTHI/MTLO, or at reset.
- MTHI/MTLO update HI/LO one edge after the write request.

## Test plan
- MULT: A = 0xFFFFFFFD (-3), B = 5, Start pulse. Expect Busy for 33 cycles, Done one cycle, HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- MULTU: A = B = 0xFFFFFFFF. Expect HI = 0xFFFFFFFE, LO = 0x00000001, DivByZero = 0.
- DIV and DIVU:
  - DIV A = 0xFFFFFFF9 (-7), B = 2: expect LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIVU A = 100, B = 7: expect LO = 14, HI = 2.
  - DIV 0x80000000 / 0xFFFFFFFF: expect LO = 0x80000000, HI = 0.
- DIVU by zero: A = 0x1234, B = 0. Expect Done and DivByZero together after the full latency, LO = 0xFFFFFFFF, HI = 0x1234.
- Start at E10 during MULT 6×7 is ignored: result stays HI = 0, LO = 42. HIWrite with 0xAAAA during Busy is ignored. HIWrite with 0xAAAA in IDLE gives HI = 0xAAAA next cycle.
- Drive reset = 0 for one edge at cycle 15 of a DIV. Expect Busy = 0, HI = LO = 0, and no Done. A following MULT 2×3 completes normally with LO = 6.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 32-step multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use MSB-first shift-add; DIV/DIVU use restoring division on operand magnitudes.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       MDOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HIWrite,
    input  logic             LOWrite,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q;
    logic               is_div_q;
    logic               neg_q;
    logic               rem_neg_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   raw_a_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_out_q;

    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    always_comb begin
        signed_op = ~MDOp[0];
        a_neg     = signed_op & A[WIDTH-1];
        b_neg     = signed_op & B[WIDTH-1];
        a_mag     = a_neg ? -A : A;
        b_mag     = b_neg ? -B : B;
    end

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] addend;
    logic             ge;

    // Divide: {remainder, next dividend bit} is a 33-bit value; its top bit forces
    // a successful subtract, so only the low 32 bits need the actual difference.
    always_comb begin
        shifted = {acc_q[2*WIDTH-1:WIDTH], a_q[cnt_q]};
        trial   = shifted[WIDTH-1:0] - b_q;
        ge      = shifted[WIDTH] | (shifted[WIDTH-1:0] >= b_q);
        addend  = b_q[cnt_q] ? a_q : '0;
        if (is_div_q) begin
            acc_d = {(ge ? trial : shifted[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
        end else begin
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0} + {{WIDTH{1'b0}}, addend};
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (!is_div_q) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (dbz_q) begin
            res_hi = raw_a_q;
            res_lo = '1;
        end else begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            raw_a_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (HIWrite) hi_q <= WriteData;
                    if (LOWrite) lo_q <= WriteData;
                    if (Start) begin
                        state_q   <= CALC;
                        busy_q    <= 1'b1;
                        is_div_q  <= MDOp[1];
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        dbz_q     <= MDOp[1] & (B == '0);
                        a_q       <= a_mag;
                        b_q       <= b_mag;
                        raw_a_q   <= A;
                        acc_q     <= '0;
                        cnt_q     <= CW'(WIDTH - 1);
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    hi_q      <= res_hi;
                    lo_q      <= res_lo;
                    done_q    <= 1'b1;
                    dbz_out_q <= dbz_q;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivByZero = dbz_out_q;
    assign HI        = hi_q;
    assign LO        = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expectations are queued when an operation
// is started and popped when Done is observed.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [1:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        HIWrite;
    logic        LOWrite;
    logic [31:0] WriteData;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic [31:0] HI;
    logic [31:0] LO;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
        .HIWrite(HIWrite), .LOWrite(LOWrite), .WriteData(WriteData),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    int          n;
    int          busy_n;
    logic [31:0] got_hi;
    logic [31:0] got_lo;
    logic        got_dbz;

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        r;
        longint      sa;
        longint      sb;
        longint      sp;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r.dbz = 1'b0;
        r.hi = '0;
        r.lo = '0;
        case (op)
            2'b00: begin sp = sa * sb; r.hi = sp[63:32]; r.lo = sp[31:0]; end
            2'b01: begin up = {32'h0, a} * {32'h0, b}; r.hi = up[63:32]; r.lo = up[31:0]; end
            default: begin
                if (b == 32'h0) begin
                    r.hi = a; r.lo = 32'hFFFFFFFF; r.dbz = 1'b1;
                end else if (op == 2'b10) begin
                    sp = sa / sb; r.lo = sp[31:0];
                    sp = sa % sb; r.hi = sp[31:0];
                end else begin
                    r.lo = a / b; r.hi = a % b;
                end
            end
        endcase
        return r;
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        MDOp = op; A = a; B = b; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; A = $urandom; B = $urandom; MDOp = 2'($urandom);
    endtask

    // Called at the negedge just after the Start edge (counted as edge 1).
    task automatic wait_done();
        n = 1;
        busy_n = 0;
        while (Done !== 1'b1 && n < 100) begin
            if (Busy === 1'b1) busy_n++;
            @(negedge clk);
            n++;
        end
        got_hi = HI; got_lo = LO; got_dbz = DivByZero;
    endtask

    task automatic test_reset();
        reset = 1'b0; Start = 1'b0; MDOp = 2'b00; A = '0; B = '0;
        HIWrite = 1'b0; LOWrite = 1'b0; WriteData = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({Busy, Done, DivByZero} !== 3'b000)
            $display("FAIL reset_ctrl got busy/done/dbz=%b%b%b exp 000", Busy, Done, DivByZero);
        total++;
        if (HI !== 32'h0 || LO !== 32'h0) begin
            bad++; $display("FAIL reset_hilo got hi=%h lo=%h exp 0/0", HI, LO);
        end
        if ({Busy, Done, DivByZero} !== 3'b000) bad++;
        reset = 1'b1;
    endtask

    task automatic test_mult();
        logic [1:0]  op[2];
        logic [31:0] ta[2];
        logic [31:0] tb[2];
        exp_t        ex[2];
        op[0] = 2'b00; ta[0] = 32'hFFFFFFFD; tb[0] = 32'd5;       ex[0] = {32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        op[1] = 2'b01; ta[1] = 32'hFFFFFFFF; tb[1] = 32'hFFFFFFFF; ex[1] = {32'hFFFFFFFE, 32'h00000001, 1'b0};
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(ex[i]);
            start_op(op[i], ta[i], tb[i]);
            wait_done();
            e = sb_q.pop_front();
            total++;
            if (n !== 34) begin bad++; $display("FAIL mult%0d_latency got %0d exp 34", i, n); end
            total++;
            if (busy_n !== 33) begin bad++; $display("FAIL mult%0d_busy got %0d exp 33", i, busy_n); end
            total++;
            if ({got_hi, got_lo, got_dbz} !== e) begin
                bad++;
                $display("FAIL mult%0d_result got hi=%h lo=%h dbz=%b exp hi=%h lo=%h dbz=%b",
                         i, got_hi, got_lo, got_dbz, e.hi, e.lo, e.dbz);
            end
            @(negedge clk);
            total++;
            if (Done !== 1'b0 || Busy !== 1'b0) begin
                bad++; $display("FAIL mult%0d_pulse got done=%b busy=%b exp 0/0", i, Done, Busy);
            end
        end
    endtask

    task automatic test_div();
        logic [1:0]  op[4];
        logic [31:0] ta[4];
        logic [31:0] tb[4];
        exp_t        ex[4];
        op[0] = 2'b10; ta[0] = 32'hFFFFFFF9; tb[0] = 32'd2;        ex[0] = {32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        op[1] = 2'b11; ta[1] = 32'd100;      tb[1] = 32'd7;        ex[1] = {32'd2, 32'd14, 1'b0};
        op[2] = 2'b10; ta[2] = 32'h80000000; tb[2] = 32'hFFFFFFFF; ex[2] = {32'h0, 32'h80000000, 1'b0};
        op[3] = 2'b11; ta[3] = 32'h1234;     tb[3] = 32'h0;        ex[3] = {32'h1234, 32'hFFFFFFFF, 1'b1};
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(ex[i]);
            start_op(op[i], ta[i], tb[i]);
            wait_done();
            e = sb_q.pop_front();
            total++;
            if (n !== 34) begin bad++; $display("FAIL div%0d_latency got %0d exp 34", i, n); end
            total++;
            if ({got_hi, got_lo, got_dbz} !== e) begin
                bad++;
                $display("FAIL div%0d_result got hi=%h lo=%h dbz=%b exp hi=%h lo=%h dbz=%b",
                         i, got_hi, got_lo, got_dbz, e.hi, e.lo, e.dbz);
            end
            @(negedge clk);
            total++;
            if (DivByZero !== 1'b0 || Done !== 1'b0) begin
                bad++; $display("FAIL div%0d_pulse got done=%b dbz=%b exp 0/0", i, Done, DivByZero);
            end
        end
    endtask

    task automatic test_ignore_busy();
        sb_q.push_back({32'h0, 32'd42, 1'b0});
        start_op(2'b00, 32'd6, 32'd7);
        n = 1;
        while (Done !== 1'b1 && n < 100) begin
            Start = (n == 10);
            if (n == 10) begin MDOp = 2'b11; A = 32'd100; B = 32'd3; end
            HIWrite = (n == 12);
            WriteData = 32'hAAAA;
            @(negedge clk);
            n++;
        end
        Start = 1'b0; HIWrite = 1'b0;
        e = sb_q.pop_front();
        total++;
        if (n !== 34) begin bad++; $display("FAIL ignore_latency got %0d exp 34", n); end
        total++;
        if (HI !== e.hi || LO !== e.lo) begin
            bad++; $display("FAIL ignore_result got hi=%h lo=%h exp hi=%h lo=%h", HI, LO, e.hi, e.lo);
        end
        @(negedge clk);
        total++;
        if (Busy !== 1'b0) begin bad++; $display("FAIL ignore_restart got busy=%b exp 0", Busy); end
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        HIWrite = 1'b1; WriteData = 32'hAAAA;
        total++;
        if (HI !== 32'h0) begin bad++; $display("FAIL mthi_early got %h exp 00000000", HI); end
        @(negedge clk);
        HIWrite = 1'b0;
        total++;
        if (HI !== 32'hAAAA || LO !== 32'd42) begin
            bad++; $display("FAIL mthi got hi=%h lo=%h exp 0000aaaa/0000002a", HI, LO);
        end
        LOWrite = 1'b1; WriteData = 32'h1357;
        @(negedge clk);
        LOWrite = 1'b0;
        total++;
        if (LO !== 32'h1357 || HI !== 32'hAAAA) begin
            bad++; $display("FAIL mtlo got hi=%h lo=%h exp 0000aaaa/00001357", HI, LO);
        end
        // MTHI together with Start: write lands first, result overwrites it.
        sb_q.push_back({32'h0, 32'd12, 1'b0});
        HIWrite = 1'b1; WriteData = 32'hDEAD; MDOp = 2'b01; A = 32'd3; B = 32'd4; Start = 1'b1;
        @(negedge clk);
        HIWrite = 1'b0; Start = 1'b0; A = $urandom; B = $urandom;
        total++;
        if (HI !== 32'hDEAD || Busy !== 1'b1) begin
            bad++; $display("FAIL mt_with_start got hi=%h busy=%b exp 0000dead/1", HI, Busy);
        end
        wait_done();
        e = sb_q.pop_front();
        total++;
        if ({got_hi, got_lo, got_dbz} !== e) begin
            bad++; $display("FAIL mt_start_result got hi=%h lo=%h exp hi=%h lo=%h", got_hi, got_lo, e.hi, e.lo);
        end
    endtask

    task automatic test_reset_abort();
        int dones;
        sb_q.push_back(model(2'b10, 32'd1000, 32'hFFFFFFFD));
        start_op(2'b10, 32'd1000, 32'hFFFFFFFD);
        n = 1;
        while (n < 15 && Done !== 1'b1) begin @(negedge clk); n++; end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        void'(sb_q.pop_front());
        total++;
        if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0 || Done !== 1'b0) begin
            bad++; $display("FAIL abort_state got busy=%b done=%b hi=%h lo=%h exp 0/0/0/0", Busy, Done, HI, LO);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done === 1'b1 || Busy === 1'b1) dones++;
        end
        total++;
        if (dones !== 0) begin bad++; $display("FAIL abort_quiet got %0d active cycles exp 0", dones); end
        sb_q.push_back({32'h0, 32'd6, 1'b0});
        start_op(2'b00, 32'd2, 32'd3);
        wait_done();
        e = sb_q.pop_front();
        total++;
        if (n !== 34 || {got_hi, got_lo, got_dbz} !== e) begin
            bad++; $display("FAIL abort_recover got n=%0d hi=%h lo=%h exp n=34 hi=%h lo=%h", n, got_hi, got_lo, e.hi, e.lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        op = 2'b00; a = $urandom; b = $urandom;
        sb_q.push_back(model(op, a, b));
        @(negedge clk);
        MDOp = op; A = a; B = b; Start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            Start = 1'b0; A = $urandom; B = $urandom;
            wait_done();
            e = sb_q.pop_front();
            total++;
            if (n !== 34 || {got_hi, got_lo, got_dbz} !== e) begin
                bad++;
                $display("FAIL b2b%0d got n=%0d hi=%h lo=%h dbz=%b exp n=34 hi=%h lo=%h dbz=%b",
                         k, n, got_hi, got_lo, got_dbz, e.hi, e.lo, e.dbz);
            end
            if (k < 5) begin
                op = 2'(k + 1);
                a = $urandom;
                b = (k == 2) ? 32'h0 : $urandom;
                if (k == 3) b = $urandom_range(1, 255);
                sb_q.push_back(model(op, a, b));
                MDOp = op; A = a; B = b; Start = 1'b1;
            end
        end
        @(negedge clk);
        total++;
        if (Busy !== 1'b0 || sb_q.size() != 0) begin
            bad++; $display("FAIL b2b_drain got busy=%b pending=%0d exp 0/0", Busy, sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_ignore_busy();
        test_mthi_mtlo();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
